// File: rtl/clk_sel_sequencer.sv
// Sequences glitch-free clock mux select changes: accepts one request, settles SETTLE_CYCLES, then responds.
// Request stalls (req_ready_o low) outside IDLE; response held until rsp_ready_i; no overlap of the two.
module clk_sel_sequencer #(
  parameter int NUM_INPUTS    = 10,
  parameter int SETTLE_CYCLES = 64,
  parameter int RESET_SEL     = 0,
  localparam int SEL_WIDTH    = $clog2(NUM_INPUTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [SEL_WIDTH-1:0] req_sel_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_err_o,
  output logic [SEL_WIDTH-1:0] sel_o,
  output logic                 switching_o
);

  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SETTLE_LOAD_I = SETTLE_CYCLES - 1;
  localparam logic [CNT_W-1:0]     SETTLE_LOAD = SETTLE_LOAD_I[CNT_W-1:0];
  localparam logic [SEL_WIDTH:0]   NUM_IN_W    = NUM_INPUTS[SEL_WIDTH:0];
  localparam logic [SEL_WIDTH-1:0] RST_SEL_W   = RESET_SEL[SEL_WIDTH-1:0];

  if (NUM_INPUTS < 2) begin : g_bad_num_inputs
    $error("clk_sel_sequencer: NUM_INPUTS must be >= 2");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("clk_sel_sequencer: SETTLE_CYCLES must be >= 1");
  end
  if (RESET_SEL >= NUM_INPUTS || RESET_SEL < 0) begin : g_bad_reset_sel
    $error("clk_sel_sequencer: RESET_SEL must be in [0, NUM_INPUTS)");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t               state_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic                 switching_q;
  logic                 req_out_of_range;
  logic                 req_same_sel;

  assign req_out_of_range = ({1'b0, req_sel_i} >= NUM_IN_W);
  assign req_same_sel     = (req_sel_i == sel_q);

  // Ready is masked by reset so it reads 0 while rst_i is held, independent of req_valid_i.
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign sel_o       = sel_q;
  assign switching_o = switching_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_q       <= RST_SEL_W;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      switching_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            if (req_out_of_range) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else if (req_same_sel) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
            end else begin
              state_q     <= SETTLE;
              sel_q       <= req_sel_i;
              cnt_q       <= SETTLE_LOAD;
              switching_q <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            switching_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          switching_q <= 1'b0;
        end
      endcase
    end
  end

  // A stalled requester must keep its request and index steady until accepted.
  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_valid_i && !req_ready_o) |=> (req_valid_i && $stable(req_sel_i)));

  a_err_needs_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_err_o |-> rsp_valid_o);

  a_no_overlap: assert property (@(posedge clk_i) disable iff (rst_i)
    !(req_ready_o && (rsp_valid_o || switching_o)));

endmodule

// File: tb/tb_clk_sel_sequencer.sv
// Directed plus random bench for clk_sel_sequencer with a response scoreboard.
module tb_clk_sel_sequencer;
  localparam int N  = 10;
  localparam int SC = 64;
  localparam int RS = 0;
  localparam int SW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [SW-1:0] req_sel_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic          rsp_err_o;
  logic [SW-1:0] sel_o;
  logic          switching_o;

  clk_sel_sequencer #(
    .NUM_INPUTS   (N),
    .SETTLE_CYCLES(SC),
    .RESET_SEL    (RS)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_sel_i  (req_sel_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_err_o  (rsp_err_o),
    .sel_o      (sel_o),
    .switching_o(switching_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          err;
    logic [SW-1:0] sel;
    int            lat;
    int            sw;
  } exp_t;

  exp_t          q[$];
  logic [SW-1:0] model_sel;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [SW-1:0] s);
    exp_t e;
    int   n;
    n = 0;
    req_valid_i = 1'b1;
    req_sel_i   = s;
    while (!req_ready_o && n < 200) begin
      step();
      n++;
    end
    chk("req_accept_wait", {31'd0, (n < 200)}, 32'd1);
    if (n >= 200) begin
      req_valid_i = 1'b0;
      return;
    end
    step();
    req_valid_i = 1'b0;
    if (s >= N) begin
      e.err = 1'b1; e.sel = model_sel; e.lat = 0; e.sw = 0;
    end else if (s == model_sel) begin
      e.err = 1'b0; e.sel = model_sel; e.lat = 0; e.sw = 0;
    end else begin
      model_sel = s;
      e.err = 1'b0; e.sel = s; e.lat = SC; e.sw = SC;
    end
    q.push_back(e);
  endtask

  task automatic wait_rsp(input int hold, input bit pend, input logic [SW-1:0] ps);
    exp_t e;
    int   cyc;
    int   sw;
    bit   bad;
    bit   bad_hold;
    if (q.size() == 0) return;
    e = q.pop_front();
    cyc = 0; sw = 0; bad = 1'b0; bad_hold = 1'b0;
    chk("sel_after_accept", sel_o, e.sel);
    if (switching_o) sw++;
    while (!rsp_valid_o && cyc < SC + 100) begin
      if (rsp_err_o !== 1'b0) bad = 1'b1;
      step();
      cyc++;
      if (switching_o) sw++;
      if (sel_o !== e.sel) bad = 1'b1;
    end
    chk("rsp_latency", cyc, e.lat);
    chk("switching_cycles", sw, e.sw);
    chk("settle_err_sel_stable", {31'd0, bad}, 32'd0);
    chk("rsp_err", rsp_err_o, e.err);
    if (pend) begin
      req_valid_i = 1'b1;
      req_sel_i   = ps;
    end
    for (int i = 0; i < hold; i++) begin
      step();
      if (rsp_valid_o !== 1'b1 || rsp_err_o !== e.err || req_ready_o !== 1'b0) bad_hold = 1'b1;
    end
    if (hold > 0) chk("rsp_hold_stall", {31'd0, bad_hold}, 32'd0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("rsp_drop_after_hs", rsp_valid_o, 0);
    chk("ready_after_hs", req_ready_o, 1);
  endtask

  initial begin
    model_sel = RS;
    #2;
    chk("rst_sel", sel_o, RS);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_switching", switching_o, 0);
    step();
    step();
    rst_i = 1'b0;
    #1;
    chk("ready_after_rst", req_ready_o, 1);

    issue(4'd7);  wait_rsp(0, 1'b0, '0);
    issue(4'd12); wait_rsp(0, 1'b0, '0);
    issue(4'd7);  wait_rsp(0, 1'b0, '0);
    issue(4'd9);  wait_rsp(1, 1'b0, '0);
    issue(4'd10); wait_rsp(0, 1'b0, '0);
    issue(4'd15); wait_rsp(2, 1'b0, '0);
    issue(4'd0);  wait_rsp(0, 1'b0, '0);
    issue(4'd3);  wait_rsp(20, 1'b1, 4'd5);
    issue(4'd5);  wait_rsp(0, 1'b0, '0);

    issue(4'd8);
    repeat (33) step();
    chk("mid_settle_switching", switching_o, 1);
    chk("mid_settle_sel", sel_o, 8);
    rst_i = 1'b1;
    #1;
    chk("abort_sel", sel_o, RS);
    chk("abort_switching", switching_o, 0);
    chk("abort_rsp_valid", rsp_valid_o, 0);
    chk("abort_ready", req_ready_o, 0);
    q.delete();
    model_sel = RS;
    step();
    step();
    rst_i = 1'b0;
    #1;
    chk("abort_ready_after_release", req_ready_o, 1);
    step();
    chk("abort_no_rsp", rsp_valid_o, 0);

    for (int r = 0; r < 150; r++) begin
      issue(SW'($urandom_range(0, 15)));
      wait_rsp(int'($urandom_range(0, 3)), 1'b0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
